// File: rtl/sfifo_prot_if.sv
// sfifo_prot_if: request/response bundle of the protected synchronous FIFO
interface sfifo_prot_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          flush, we, re, clr_err;
    logic [DW-1:0] d, q;
    logic          rvalid, rempty, wfull, almost_full, almost_empty;
    logic          overflow, underflow;
    logic [AW:0]   cnt, max_cnt;
    modport master (
        output flush, we, d, re, clr_err,
        input  q, rvalid, rempty, wfull, almost_full, almost_empty, cnt, max_cnt, overflow, underflow
    );
    modport slave (
        input  flush, we, d, re, clr_err,
        output q, rvalid, rempty, wfull, almost_full, almost_empty, cnt, max_cnt, overflow, underflow
    );
endinterface

// File: rtl/sfifo_prot.sv
// sfifo_prot: single-clock FIFO with accept protection, almost flags, flush,
// sticky overflow/underflow and an occupancy high-watermark.
module sfifo_prot #(
    parameter int DW         = 32,
    parameter int AW         = 4,
    parameter int SHOW_AHEAD = 0,
    parameter int AF_TH      = 2**AW-2,
    parameter int AE_TH      = 2
) (
    input logic         clk,
    input logic         rst_n,
    sfifo_prot_if.slave bus
);
    localparam logic [AW:0] FULL_C = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_C   = (AW+1)'(AF_TH);
    localparam logic [AW:0] AE_C   = (AW+1)'(AE_TH);
    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wa, ra, wa_nx, ra_nx, cnt, cnt_nx, max_cnt;
    logic          rd_ok, wr_ok, rd_acc, wr_acc, ov, un;
    assign cnt    = wa - ra;
    assign rd_ok  = bus.re & (cnt != '0);
    // a read frees a slot in the same cycle, so a full FIFO still accepts we&re
    assign wr_ok  = bus.we & ((cnt != FULL_C) | rd_ok);
    assign rd_acc = rd_ok & ~bus.flush;
    assign wr_acc = wr_ok & ~bus.flush;
    assign wa_nx  = bus.flush ? '0 : wa + {{AW{1'b0}}, wr_ok};
    assign ra_nx  = bus.flush ? '0 : ra + {{AW{1'b0}}, rd_ok};
    assign cnt_nx = wa_nx - ra_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa      <= '0;
            ra      <= '0;
            max_cnt <= '0;
            ov      <= 1'b0;
            un      <= 1'b0;
        end else begin
            wa      <= wa_nx;
            ra      <= ra_nx;
            max_cnt <= (bus.clr_err || cnt_nx > max_cnt) ? cnt_nx : max_cnt;
            ov      <= (bus.we & ~wr_ok & ~bus.flush) | (ov & ~bus.clr_err);
            un      <= (bus.re & ~rd_ok & ~bus.flush) | (un & ~bus.clr_err);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wa[AW-1:0]] <= bus.d;
    end
    generate
        if (SHOW_AHEAD != 0) begin : g_sa
            assign bus.q      = mem[ra[AW-1:0]];
            assign bus.rvalid = cnt != '0;
        end else begin : g_reg
            logic [DW-1:0] q_r;
            logic          rv_r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r  <= '0;
                    rv_r <= 1'b0;
                end else begin
                    rv_r <= rd_acc;
                    if (rd_acc) q_r <= mem[ra[AW-1:0]];
                end
            end
            assign bus.q      = q_r;
            assign bus.rvalid = rv_r;
        end
    endgenerate
    assign bus.cnt          = cnt;
    assign bus.max_cnt      = max_cnt;
    assign bus.rempty       = cnt == '0;
    assign bus.wfull        = cnt == FULL_C;
    assign bus.almost_full  = cnt >= AF_C;
    assign bus.almost_empty = cnt <= AE_C;
    assign bus.overflow     = ov;
    assign bus.underflow    = un;
endmodule

// File: tb/tb_sfifo_prot.sv
// tb_sfifo_prot: directed vector table plus hand-written corner sequences for
// a registered-output and a show-ahead instance of sfifo_prot.
module tb_sfifo_prot;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    sfifo_prot_if #(.DW(32), .AW(4)) b ();
    sfifo_prot_if #(.DW(32), .AW(4)) s ();
    sfifo_prot #(.DW(32), .AW(4), .SHOW_AHEAD(0)) u_reg (.clk(clk), .rst_n(rst_n), .bus(b));
    sfifo_prot #(.DW(32), .AW(4), .SHOW_AHEAD(1)) u_sa  (.clk(clk), .rst_n(rst_n), .bus(s));
    typedef struct {
        logic        we, re, fl, clr;
        logic [31:0] d;
        logic [4:0]  cnt;
        logic        em, fu, af, ae, rv, ov, un;
        logic [31:0] q;
        logic [4:0]  mx;
    } vec_t;
    vec_t tbl [12];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic chk_st(input string nm, input logic [4:0] c,
                          input logic em, fu, af, ae, rv, ov, un);
        chk(nm, {b.cnt, b.rempty, b.wfull, b.almost_full, b.almost_empty, b.rvalid, b.overflow, b.underflow},
                {c, em, fu, af, ae, rv, ov, un});
    endtask
    task automatic drv(input logic we, re, fl, clr, input logic [31:0] d);
        b.we = we; b.re = re; b.flush = fl; b.clr_err = clr; b.d = d;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        drv(0, 0, 0, 0, 0);
        s.we = 0; s.re = 0; s.flush = 0; s.clr_err = 0; s.d = 0;
        // vectors start from empty: {we,re,flush,clr,d} -> {cnt,em,fu,af,ae,rv,ov,un,q,max}
        tbl[0]  = '{1, 0, 0, 0, 32'h11, 5'd1, 0, 0, 0, 1, 0, 0, 0, 32'h00, 5'd1};
        tbl[1]  = '{1, 0, 0, 0, 32'h22, 5'd2, 0, 0, 0, 1, 0, 0, 0, 32'h00, 5'd2};
        tbl[2]  = '{1, 0, 0, 0, 32'h33, 5'd3, 0, 0, 0, 0, 0, 0, 0, 32'h00, 5'd3};
        tbl[3]  = '{0, 1, 0, 0, 32'h00, 5'd2, 0, 0, 0, 1, 1, 0, 0, 32'h11, 5'd3};
        tbl[4]  = '{1, 1, 0, 0, 32'h44, 5'd2, 0, 0, 0, 1, 1, 0, 0, 32'h22, 5'd3};
        tbl[5]  = '{0, 0, 0, 0, 32'h00, 5'd2, 0, 0, 0, 1, 0, 0, 0, 32'h22, 5'd3};
        tbl[6]  = '{0, 1, 0, 0, 32'h00, 5'd1, 0, 0, 0, 1, 1, 0, 0, 32'h33, 5'd3};
        tbl[7]  = '{0, 1, 0, 0, 32'h00, 5'd0, 1, 0, 0, 1, 1, 0, 0, 32'h44, 5'd3};
        tbl[8]  = '{0, 1, 0, 0, 32'h00, 5'd0, 1, 0, 0, 1, 0, 0, 1, 32'h44, 5'd3};
        tbl[9]  = '{1, 1, 0, 0, 32'h55, 5'd1, 0, 0, 0, 1, 0, 0, 1, 32'h44, 5'd3};
        tbl[10] = '{0, 0, 0, 1, 32'h00, 5'd1, 0, 0, 0, 1, 0, 0, 0, 32'h44, 5'd1};
        tbl[11] = '{0, 1, 0, 0, 32'h00, 5'd0, 1, 0, 0, 1, 1, 0, 0, 32'h55, 5'd1};
        step(); step();
        chk_st("reset_status", 0, 1, 0, 0, 1, 0, 0, 0);
        chk("reset_q", b.q, 0);
        chk("reset_max", 32'(b.max_cnt), 0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            drv(tbl[i].we, tbl[i].re, tbl[i].fl, tbl[i].clr, tbl[i].d);
            step();
            chk($sformatf("vec%0d_status", i),
                {b.cnt, b.rempty, b.wfull, b.almost_full, b.almost_empty, b.rvalid, b.overflow, b.underflow},
                {tbl[i].cnt, tbl[i].em, tbl[i].fu, tbl[i].af, tbl[i].ae, tbl[i].rv, tbl[i].ov, tbl[i].un});
            chk($sformatf("vec%0d_q", i), b.q, tbl[i].q);
            chk($sformatf("vec%0d_max", i), 32'(b.max_cnt), 32'(tbl[i].mx));
        end
        // fill to full, then one rejected write
        for (int i = 1; i <= 16; i++) begin
            drv(1, 0, 0, 0, 32'(i));
            step();
            chk_st($sformatf("fill%0d", i), 5'(i), 0, i == 16, i >= 14, i <= 2, 0, 0, 0);
        end
        chk("fill_max", 32'(b.max_cnt), 16);
        drv(1, 0, 0, 0, 32'h99);
        step();
        chk_st("overflow_set", 16, 0, 1, 1, 0, 0, 1, 0);
        drv(0, 0, 0, 1, 0);
        step();
        chk_st("overflow_clr", 16, 0, 1, 1, 0, 0, 0, 0);
        chk("clr_max_reload", 32'(b.max_cnt), 16);
        // full streaming across pointer wrap
        for (int k = 0; k < 40; k++) begin
            drv(1, 1, 0, 0, 32'(17 + k));
            step();
            chk_st($sformatf("stream%0d", k), 16, 0, 1, 1, 0, 1, 0, 0);
            chk($sformatf("stream%0d_q", k), b.q, 32'(k + 1));
        end
        for (int i = 0; i < 16; i++) begin
            drv(0, 1, 0, 0, 0);
            step();
            chk($sformatf("drain%0d_q", i), b.q, 32'(41 + i));
            chk_st($sformatf("drain%0d", i), 5'(15 - i), i == 15, 0, (15 - i) >= 14, (15 - i) <= 2, 1, 0, 0);
        end
        drv(0, 1, 0, 0, 0);
        step();
        chk_st("underflow_set", 0, 1, 0, 0, 1, 0, 0, 1);
        chk("underflow_q_hold", b.q, 56);
        // flush at cnt=9 with concurrent we&re
        drv(0, 0, 0, 1, 0);
        step();
        chk("clr_max_zero", 32'(b.max_cnt), 0);
        for (int i = 0; i < 9; i++) begin
            drv(1, 0, 0, 0, 32'(100 + i));
            step();
        end
        chk_st("pre_flush", 9, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 1, 0, 32'hdead);
        step();
        chk_st("flush", 0, 1, 0, 0, 1, 0, 0, 0);
        chk("flush_max", 32'(b.max_cnt), 9);
        chk("flush_q_hold", b.q, 56);
        drv(0, 0, 0, 1, 0);
        step();
        chk("flush_clr_max", 32'(b.max_cnt), 0);
        drv(1, 0, 0, 0, 32'h200);
        step();
        drv(0, 1, 0, 0, 0);
        step();
        chk("post_flush_q", b.q, 32'h200);
        chk_st("post_flush", 0, 1, 0, 0, 1, 1, 0, 0);
        drv(0, 0, 0, 0, 0);
        // show-ahead instance
        s.we = 1; s.d = 32'ha5;
        step();
        s.d = 32'hb6;
        chk("sa_q_first", s.q, 32'ha5);
        chk("sa_rv_first", {s.rvalid, s.rempty}, 2'b10);
        step();
        s.we = 0; s.re = 1;
        chk("sa_q_head", s.q, 32'ha5);
        step();
        chk("sa_q_next", s.q, 32'hb6);
        step();
        s.re = 0;
        chk("sa_empty", {s.rvalid, s.rempty, s.underflow}, 3'b010);
        // async reset mid-stream with overflow set and cnt=7
        for (int i = 0; i < 17; i++) begin
            drv(1, 0, 0, 0, 32'(i));
            step();
        end
        for (int i = 0; i < 9; i++) begin
            drv(0, 1, 0, 0, 0);
            step();
        end
        drv(0, 0, 0, 0, 0);
        chk_st("pre_reset", 7, 0, 0, 0, 0, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_st("async_reset", 0, 1, 0, 0, 1, 0, 0, 0);
        chk("async_reset_q", b.q, 0);
        chk("async_reset_max", 32'(b.max_cnt), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 0, 0, 32'(32'h300 + i));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 0, 0, 0);
            step();
            chk($sformatf("post_reset_q%0d", i), b.q, 32'(32'h300 + i));
        end
        drv(0, 0, 0, 0, 0);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sfifo_prot.md
Name: sfifo_prot

Overview:
- Parametrised synchronous single-clock FIFO. Next generation of the team's simple dual-port FIFO.
- Adds write/read protection, read-data valid strobe, programmable almost-full/almost-empty flags, synchronous flush, sticky overflow/underflow errors and a high-watermark counter.
- Sits between DMA engine stages, e.g. the AXI read-data path to the write channel, in the same clock domain.

Parameters:
- DW, 32, data width in bits.
- AW, 4, address width; DEPTH = 2**AW entries.
- SHOW_AHEAD, 0:
  - 1: q presents the head entry combinationally.
  - 0: q is registered, one cycle after an accepted read.
- AF_TH, 2**AW-2, almost_full asserts when cnt >= AF_TH. Range 1..DEPTH.
- AE_TH, 2, almost_empty asserts when cnt <= AE_TH. Range 0..DEPTH-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of pointers and count.
- we  in  1  write request.
- d  in  DW  write data.
- re  in  1  read request.
- q  out  DW  read data.
- rvalid  out  1  q holds data from an accepted read. Non-show-ahead: pulses the cycle after acceptance. Show-ahead: equals ~rempty.
- rempty  out  1  cnt == 0.
- wfull  out  1  cnt == DEPTH.
- almost_full  out  1  cnt >= AF_TH.
- almost_empty  out  1  cnt <= AE_TH.
- cnt  out  AW+1  current occupancy, 0..DEPTH.
- max_cnt  out  AW+1  highest cnt since reset or clr_err.
- overflow  out  1  sticky: a write was attempted while full and not accepted.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  clears overflow, underflow and max_cnt (max_cnt reloads with the current cnt).

Behaviour:
- Pointers wa, ra are AW+1 bits. cnt = wa - ra, modulo 2**(AW+1). Storage is indexed by the low AW bits. Pointer wrap is natural binary rollover.
- Read acceptance: rd_ok = re & ~rempty.
- Write acceptance: wr_ok = we & (~wfull | rd_ok). A simultaneous read and write when full is accepted; cnt stays DEPTH.
- Empty with we&re: write accepted, read rejected. underflow is set; cnt becomes 1.
- Rejected requests leave pointers, storage and q unchanged.
- overflow sets on we & ~wr_ok. underflow sets on re & ~rd_ok. Both hold until clr_err or reset.
- If clr_err coincides with a new error event, the set wins.
- Non-show-ahead:
  - q <= storage[ra] on rd_ok, otherwise q holds.
  - rvalid <= rd_ok.
  - Read latency is 1 cycle.
- Show-ahead:
  - q = storage[ra] combinationally; it is valid only while ~rempty.
  - A write to an empty FIFO is visible on q the next cycle.
- Flush:
  - On the next edge, wa = ra = 0, cnt = 0, rvalid = 0, q holds (non-show-ahead).
  - we and re in the same cycle are ignored; no error flags are set.
  - overflow, underflow and max_cnt are unaffected.
- max_cnt <= max(max_cnt, next cnt) every cycle. clr_err loads the next cnt.
- Flags are combinational from registered cnt; there is no extra latency beyond the pointer update.
- Reset (async assert, any time including mid-burst) gives:
  - wa = ra = 0, cnt = 0, rempty = 1, wfull = 0.
  - almost_empty = 1 and almost_full = 0 (given AE_TH >= 0 and AF_TH >= 1).
  - rvalid = 0, overflow = underflow = 0, max_cnt = 0, registered q = 0.
  - Storage is not reset.

Test Plan:
- Fill AW=4, 16 writes of 0x1..0x10 with no reads -> wfull=1, cnt=16, almost_full from the 14th write, max_cnt=16. A 17th write sets overflow=1 with cnt still 16.
- Drain non-show-ahead: 16 reads -> q = 0x1..0x10 each one cycle after re, with rvalid pulsing. A 17th re sets underflow=1, rvalid=0 and q holds 0x10.
- Show-ahead: a single write of 0xA5 to empty -> next cycle q=0xA5, rvalid=1. A re then empties the FIFO: rempty=1, rvalid=0.
- Full plus simultaneous we&re for 40 cycles with an incrementing pattern -> cnt stays 16, no overflow, data order preserved across pointer wrap (wa passes 31 -> 0).
- Flush at cnt=9 together with we&re -> next cycle cnt=0, rempty=1, no error set, max_cnt=9. clr_err then gives max_cnt=0.
- Assert rst_n low mid-stream at cnt=7 with overflow=1 -> immediately cnt=0, overflow=0, rvalid=0, q=0. Writes after release read back correctly.
